ad_sample_window: RTL and testbench



---
 rtl/ad_sample_window_pkg.sv | 23 ++
 rtl/ad_clk_div.sv | 52 +++++
 rtl/ad_sample_window.sv | 158 +++++++++++++++
 tb/tb_ad_sample_window.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad_sample_window_pkg.sv
// ad_sample_window_pkg
// Shared definitions for the acquisition window generator:
//   - default widths for the delay, length and divider configuration fields
//   - HOLD_CYC, the minimum low time of ad_sample_en before frame_done
//   - 3-bit gray-coded state encoding for the window state machine
package ad_sample_window_pkg;

   localparam int unsigned DEF_DELAY_W = 16;
   localparam int unsigned DEF_LEN_W   = 13;
   localparam int unsigned DEF_DIV_W   = 4;
   localparam int unsigned HOLD_CYC    = 4;
   localparam int unsigned HOLD_W      = $clog2(HOLD_CYC + 1);

   // Gray sequence along the normal path IDLE->DELAY->ARM_W->SAMPLE->HOLD.
   typedef enum logic [2:0] {
      IDLE   = 3'b000,
      DELAY  = 3'b001,
      ARM_W  = 3'b011,
      SAMPLE = 3'b010,
      HOLD   = 3'b110
   } state_t;

endpackage

// File: rtl/ad_clk_div.sv
// ad_clk_div
// Free-running divider producing the ADC / FIFO write clock.
// ad_clk toggles whenever div_cnt reaches div_l, giving a period of 2*(div_l+1) clk.
// div_l is reloaded from cfg_div only at a toggle and only while idle is high, so a
// new ratio always starts on a fresh half-period and never produces a short pulse.
// Ports:
//   clk, reset_n  system clock, asynchronous active-low reset
//   idle          window state machine is in IDLE (reload permitted)
//   cfg_div       requested half-period minus 1, in clk cycles
//   ad_clk        registered divided clock
//   ad_rise       high in the cycle whose closing clk edge drives ad_clk to 1
//   ad_fall       high in the cycle whose closing clk edge drives ad_clk to 0
module ad_clk_div
   import ad_sample_window_pkg::*;
#(
   parameter int unsigned DIV_W = DEF_DIV_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             idle,
   input  logic [DIV_W-1:0] cfg_div,
   output logic             ad_clk,
   output logic             ad_rise,
   output logic             ad_fall
);

   logic [DIV_W-1:0] div_cnt;
   logic [DIV_W-1:0] div_l;
   logic             toggle;

   assign toggle  = (div_cnt == div_l);
   // Strobes line up with the clk edge at which ad_clk actually changes.
   assign ad_rise = toggle & ~ad_clk;
   assign ad_fall = toggle & ad_clk;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ad_clk  <= 1'b0;
         div_cnt <= '0;
         div_l   <= '0;
      end else if (toggle) begin
         ad_clk  <= ~ad_clk;
         div_cnt <= '0;
         if (idle) begin
            div_l <= cfg_div;
         end
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/ad_sample_window.sv
// ad_sample_window
// Acquisition window generator feeding the external-FIFO write controller.
// A rising edge on burst_syn (synchronised, edge-detected) starts a programmed delay,
// after which ad_sample_en opens on an ad_clk falling edge and stays open for exactly
// cfg_length ad_clk rising edges, closing on the following falling edge. After a hold
// period frame_done pulses for one clk. Triggers that cannot start a frame are counted.
// Ports:
//   clk, reset_n   100 MHz system clock, asynchronous active-low reset
//   burst_syn      asynchronous pulser trigger (rising edge significant)
//   arm_idle       1 = ARM has finished reading the previous frame
//   cfg_enable     acquisition enable; low aborts an active frame
//   cfg_delay      trigger-to-window delay in clk cycles
//   cfg_length     samples per frame (0 = trigger rejected)
//   cfg_div        ad_clk half-period minus 1 in clk cycles
//   ad_clk         ADC / FIFO write clock
//   ad_sample_en   sample window enable
//   busy           state machine not in IDLE
//   frame_done     one-clk pulse at window completion
//   drop_cnt       saturating count of ignored triggers
module ad_sample_window
   import ad_sample_window_pkg::*;
#(
   parameter int unsigned DELAY_W = DEF_DELAY_W,
   parameter int unsigned LEN_W   = DEF_LEN_W,
   parameter int unsigned DIV_W   = DEF_DIV_W
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               burst_syn,
   input  logic               arm_idle,
   input  logic               cfg_enable,
   input  logic [DELAY_W-1:0] cfg_delay,
   input  logic [LEN_W-1:0]   cfg_length,
   input  logic [DIV_W-1:0]   cfg_div,
   output logic               ad_clk,
   output logic               ad_sample_en,
   output logic               busy,
   output logic               frame_done,
   output logic [7:0]         drop_cnt
);

   state_t             state;
   logic               sync1, sync2, sync3;
   logic               trig;
   logic               accept;
   logic               in_idle;
   logic               ad_rise, ad_fall;
   logic [DELAY_W-1:0] dly_l, dly_cnt;
   logic [LEN_W-1:0]   len_l, smp_cnt;
   logic [HOLD_W-1:0]  hold_cnt;

   assign in_idle = (state == IDLE);
   assign busy    = ~in_idle;
   assign accept  = trig & in_idle & cfg_enable & arm_idle & (cfg_length != '0);

   ad_clk_div #(
      .DIV_W (DIV_W)
   ) u_div (
      .clk     (clk),
      .reset_n (reset_n),
      .idle    (in_idle),
      .cfg_div (cfg_div),
      .ad_clk  (ad_clk),
      .ad_rise (ad_rise),
      .ad_fall (ad_fall)
   );

   // Two-stage synchroniser plus a history stage; trig is registered so it is a
   // clean one-clk pulse three clk edges after the external rising edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
         trig  <= 1'b0;
      end else begin
         sync1 <= burst_syn;
         sync2 <= sync1;
         sync3 <= sync2;
         trig  <= sync2 & ~sync3;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         ad_sample_en <= 1'b0;
         frame_done   <= 1'b0;
         drop_cnt     <= '0;
         dly_l        <= '0;
         dly_cnt      <= '0;
         len_l        <= '0;
         smp_cnt      <= '0;
         hold_cnt     <= '0;
      end else begin
         frame_done <= 1'b0;

         // Any trigger that does not start a frame is a drop, including one that
         // arrives together with an abort or while cfg_enable is low in IDLE.
         if (trig && !accept && drop_cnt != 8'hff) begin
            drop_cnt <= drop_cnt + 8'd1;
         end

         if (!in_idle && !cfg_enable) begin
            state        <= IDLE;
            ad_sample_en <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (accept) begin
                     dly_l   <= cfg_delay;
                     len_l   <= cfg_length;
                     dly_cnt <= '0;
                     state   <= DELAY;
                  end
               end
               DELAY: begin
                  // Counter stops at the target, so a full-scale delay cannot wrap.
                  if (dly_cnt >= dly_l) begin
                     state <= ARM_W;
                  end else begin
                     dly_cnt <= dly_cnt + DELAY_W'(1);
                  end
               end
               ARM_W: begin
                  if (ad_fall) begin
                     ad_sample_en <= 1'b1;
                     smp_cnt      <= '0;
                     state        <= SAMPLE;
                  end
               end
               SAMPLE: begin
                  if (ad_fall && smp_cnt >= len_l) begin
                     ad_sample_en <= 1'b0;
                     hold_cnt     <= '0;
                     state        <= HOLD;
                  end else if (ad_rise && smp_cnt < len_l) begin
                     smp_cnt <= smp_cnt + LEN_W'(1);
                  end
               end
               HOLD: begin
                  if (hold_cnt == HOLD_W'(HOLD_CYC - 1)) begin
                     frame_done <= 1'b1;
                     state      <= IDLE;
                  end else begin
                     hold_cnt <= hold_cnt + HOLD_W'(1);
                  end
               end
               default: begin
                  state        <= IDLE;
                  ad_sample_en <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ad_sample_window.sv
// tb_ad_sample_window
// Directed self-checking bench for ad_sample_window.
module tb_ad_sample_window;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        burst_syn = 1'b0;
   logic        arm_idle = 1'b1;
   logic        cfg_enable = 1'b1;
   logic [15:0] cfg_delay = '0;
   logic [12:0] cfg_length = '0;
   logic [3:0]  cfg_div = '0;
   logic        ad_clk;
   logic        ad_sample_en;
   logic        busy;
   logic        frame_done;
   logic [7:0]  drop_cnt;

   int checks = 0;
   int failures = 0;

   ad_sample_window dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .burst_syn    (burst_syn),
      .arm_idle     (arm_idle),
      .cfg_enable   (cfg_enable),
      .cfg_delay    (cfg_delay),
      .cfg_length   (cfg_length),
      .cfg_div      (cfg_div),
      .ad_clk       (ad_clk),
      .ad_sample_en (ad_sample_en),
      .busy         (busy),
      .frame_done   (frame_done),
      .drop_cnt     (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic wait_clks(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Drives a trigger at iteration 0 (and optionally a second one) and records the
   // window seen on the outputs, sampled at negedges, until busy has dropped.
   task automatic observe(input int budget, input int trig2_at,
                          output int rises, output int en_cycles, output int fd_cnt,
                          output int fall_to_fd, output int first_en_at,
                          output int bad_align, output bit timeout);
      bit prev_clk, prev_en, seen_busy;
      int fall_at, fd_at, tail;
      rises = 0; en_cycles = 0; fd_cnt = 0; bad_align = 0; first_en_at = -1;
      fall_at = -1; fd_at = -1; tail = -1; timeout = 1'b1; seen_busy = 1'b0;
      prev_clk = ad_clk; prev_en = ad_sample_en;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (busy) seen_busy = 1'b1;
         if (ad_sample_en) en_cycles++;
         if (ad_sample_en && !prev_en) begin
            if (first_en_at < 0) first_en_at = i;
            if (!(prev_clk && !ad_clk)) bad_align++;
         end
         if (!ad_sample_en && prev_en) begin
            fall_at = i;
            if (!(prev_clk && !ad_clk)) bad_align++;
         end
         if (ad_clk && !prev_clk && ad_sample_en) rises++;
         if (frame_done) begin
            fd_cnt++;
            if (fd_at < 0) fd_at = i;
         end
         prev_clk = ad_clk;
         prev_en  = ad_sample_en;
         burst_syn = (i < 3) || (trig2_at >= 0 && i >= trig2_at && i < trig2_at + 3);
         if (seen_busy && !busy && tail < 0) tail = i;
         if (tail >= 0 && i >= tail + 4) begin
            timeout = 1'b0;
            break;
         end
      end
      burst_syn = 1'b0;
      fall_to_fd = (fall_at >= 0 && fd_at >= 0) ? fd_at - fall_at : -1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      wait_clks(3);
      checks++; if (ad_clk !== 1'b0) begin failures++; $display("FAIL reset_ad_clk got=%b exp=0", ad_clk); end
      checks++; if (ad_sample_en !== 1'b0) begin failures++; $display("FAIL reset_en got=%b exp=0", ad_sample_en); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
      checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
      reset_n = 1'b1;
      wait_clks(2);
   endtask

   task automatic test_basic_window();
      int r, enc, fd, f2f, fe, ba, bad_run, run, nruns;
      bit to, prev;
      cfg_div = 4'd1; cfg_delay = 16'd10; cfg_length = 13'd8; arm_idle = 1'b1; cfg_enable = 1'b1;
      wait_clks(10);
      // Idle clock shape: every half-period 2 clk.
      bad_run = 0; run = 0; nruns = 0; prev = ad_clk;
      for (int i = 0; i < 40 && nruns < 6; i++) begin
         @(negedge clk);
         if (ad_clk != prev) begin
            nruns++;
            if (nruns > 1 && run != 2) bad_run++;
            run = 1;
         end else run++;
         prev = ad_clk;
      end
      checks++; if (bad_run != 0 || nruns < 6) begin failures++; $display("FAIL div1_period bad_runs=%0d runs=%0d exp 0/6", bad_run, nruns); end
      observe(200, -1, r, enc, fd, f2f, fe, ba, to);
      checks++; if (to) begin failures++; $display("FAIL basic_timeout got=1 exp=0"); end
      checks++; if (r != 8) begin failures++; $display("FAIL basic_rises got=%0d exp=8", r); end
      checks++; if (enc != 32) begin failures++; $display("FAIL basic_en_cycles got=%0d exp=32", enc); end
      checks++; if (fd != 1) begin failures++; $display("FAIL basic_fd_count got=%0d exp=1", fd); end
      checks++; if (f2f != 4) begin failures++; $display("FAIL basic_fall_to_fd got=%0d exp=4", f2f); end
      checks++; if (ba != 0) begin failures++; $display("FAIL basic_align got=%0d exp=0", ba); end
      checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL basic_drop got=%0d exp=0", drop_cnt); end
   endtask

   task automatic test_retrigger_and_arm_busy();
      int r, enc, fd, f2f, fe, ba;
      bit to, saw;
      wait_clks(5);
      observe(200, 30, r, enc, fd, f2f, fe, ba, to);
      checks++; if (to || r != 8 || enc != 32 || fd != 1) begin
         failures++; $display("FAIL retrig_window to=%0d rises=%0d en=%0d fd=%0d exp 0/8/32/1", to, r, enc, fd);
      end
      checks++; if (drop_cnt !== 8'd1) begin failures++; $display("FAIL retrig_drop got=%0d exp=1", drop_cnt); end
      arm_idle = 1'b0;
      saw = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         burst_syn = (i < 3);
         if (busy || ad_sample_en) saw = 1'b1;
      end
      checks++; if (saw) begin failures++; $display("FAIL armbusy_window got=1 exp=0"); end
      checks++; if (drop_cnt !== 8'd2) begin failures++; $display("FAIL armbusy_drop got=%0d exp=2", drop_cnt); end
      arm_idle = 1'b1;
   endtask

   task automatic test_min_window();
      int r, enc, fd, f2f, fe, ba;
      bit to;
      cfg_div = 4'd0; cfg_delay = 16'd0; cfg_length = 13'd1;
      wait_clks(10);
      observe(100, -1, r, enc, fd, f2f, fe, ba, to);
      checks++; if (to || r != 1 || enc != 2 || fd != 1) begin
         failures++; $display("FAIL min_window to=%0d rises=%0d en=%0d fd=%0d exp 0/1/2/1", to, r, enc, fd);
      end
      checks++; if (fe < 6 || fe > 7) begin failures++; $display("FAIL min_latency got=%0d exp=6..7", fe); end
      checks++; if (ba != 0) begin failures++; $display("FAIL min_align got=%0d exp=0", ba); end
   endtask

   task automatic test_abort();
      int r, enc, fd, f2f, fe, ba, fdseen;
      bit to, prev;
      cfg_div = 4'd1; cfg_delay = 16'd2; cfg_length = 13'd100;
      wait_clks(10);
      r = 0; prev = ad_clk;
      for (int i = 0; i < 100 && r < 3; i++) begin
         @(negedge clk);
         burst_syn = (i < 3);
         if (ad_clk && !prev && ad_sample_en) r++;
         prev = ad_clk;
      end
      burst_syn = 1'b0;
      checks++; if (r != 3) begin failures++; $display("FAIL abort_reach got=%0d exp=3", r); end
      cfg_enable = 1'b0;
      @(negedge clk);
      checks++; if (ad_sample_en !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL abort_next en=%b busy=%b exp 0/0", ad_sample_en, busy);
      end
      fdseen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (frame_done) fdseen++;
      end
      checks++; if (fdseen != 0) begin failures++; $display("FAIL abort_fd got=%0d exp=0", fdseen); end
      cfg_enable = 1'b1;
      wait_clks(5);
      observe(600, -1, r, enc, fd, f2f, fe, ba, to);
      checks++; if (to || r != 100 || enc != 400 || fd != 1) begin
         failures++; $display("FAIL abort_refill to=%0d rises=%0d en=%0d fd=%0d exp 0/100/400/1", to, r, enc, fd);
      end
   endtask

   task automatic test_drop_saturate();
      bit saw;
      cfg_length = 13'd0;
      saw = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         burst_syn = (i < 3);
         if (busy) saw = 1'b1;
      end
      checks++; if (saw || drop_cnt !== 8'd3) begin
         failures++; $display("FAIL len0_drop busy_seen=%0d drop=%0d exp 0/3", saw, drop_cnt);
      end
      cfg_length = 13'd8;
      arm_idle = 1'b0;
      for (int p = 0; p < 300; p++) begin
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            burst_syn = (i < 2);
         end
         if (p == 99) begin
            wait_clks(5);
            checks++; if (drop_cnt !== 8'd103) begin failures++; $display("FAIL drop_mid got=%0d exp=103", drop_cnt); end
         end
      end
      burst_syn = 1'b0;
      wait_clks(6);
      checks++; if (drop_cnt !== 8'd255) begin failures++; $display("FAIL drop_sat got=%0d exp=255", drop_cnt); end
      arm_idle = 1'b1;
   endtask

   task automatic test_async_reset_and_div_change();
      int waited, run, busy_runs, busy_bad, idle_runs, idle_bad;
      bit prev, first;
      cfg_div = 4'd0; cfg_delay = 16'd0; cfg_length = 13'd50;
      wait_clks(10);
      waited = 0;
      for (int i = 0; i < 60 && !ad_sample_en; i++) begin
         @(negedge clk);
         burst_syn = (i < 3);
         waited++;
      end
      burst_syn = 1'b0;
      wait_clks(4);
      checks++; if (ad_sample_en !== 1'b1) begin failures++; $display("FAIL rst_setup en=%b exp=1", ad_sample_en); end
      #2 reset_n = 1'b0;
      #1;
      checks++; if ({ad_clk, ad_sample_en, busy, frame_done} !== 4'b0000 || drop_cnt !== 8'd0) begin
         failures++;
         $display("FAIL async_reset clk=%b en=%b busy=%b fd=%b drop=%0d exp all 0",
                  ad_clk, ad_sample_en, busy, frame_done, drop_cnt);
      end
      @(negedge clk);
      reset_n = 1'b1;
      wait_clks(4);
      // Start a window at div 0, then request div 3 while it is running.
      cfg_length = 13'd20;
      for (int i = 0; i < 60 && !ad_sample_en; i++) begin
         @(negedge clk);
         burst_syn = (i < 3);
      end
      burst_syn = 1'b0;
      cfg_div = 4'd3;
      run = 0; busy_runs = 0; busy_bad = 0; idle_runs = 0; idle_bad = 0;
      prev = ad_clk; first = 1'b1;
      for (int i = 0; i < 300 && idle_runs < 6; i++) begin
         @(negedge clk);
         if (ad_clk != prev) begin
            if (first) first = 1'b0;
            else if (busy) begin
               busy_runs++;
               if (run != 1) busy_bad++;
            end else begin
               idle_runs++;
               if (run < 1 || (idle_runs > 2 && run != 4)) idle_bad++;
            end
            run = 1;
         end else run++;
         prev = ad_clk;
      end
      checks++; if (busy_runs == 0 || busy_bad != 0) begin
         failures++; $display("FAIL div_busy runs=%0d bad=%0d exp >0/0", busy_runs, busy_bad);
      end
      checks++; if (idle_runs < 6 || idle_bad != 0) begin
         failures++; $display("FAIL div_idle runs=%0d bad=%0d exp 6/0", idle_runs, idle_bad);
      end
   endtask

   initial begin
      test_reset();
      test_basic_window();
      test_retrigger_and_arm_busy();
      test_min_window();
      test_abort();
      test_drop_saturate();
      test_async_reset_and_div_change();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
